// File: rtl/decision_wait_driver.sv
// Clocked initiator for a two-phase decision-wait element: issues fire/a1/a2 transitions and
// synchronises the z1/z2 replies. Optional WAIT timeout and HALT state under `DW_TIMEOUT_EN.
module decision_wait_driver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic done,
  output logic done_sel,
  output logic protocol_err,
  output logic timeout,
  output logic a1,
  output logic a2,
  output logic fire,
  input  logic z1,
  input  logic z2
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("decision_wait_driver: illegal SYNC_STAGES or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] z1_sync, z2_sync;
  logic mism1, mism2, accept, ack, other_err, timeout_hit;
  logic sel_q, last_sel;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      z1_sync <= '0;
      z2_sync <= '0;
    end else begin
      z1_sync <= {z1_sync[SYNC_STAGES-2:0], z1};
      z2_sync <= {z2_sync[SYNC_STAGES-2:0], z2};
    end
  end

  // A channel is outstanding while its request phase differs from the synchronised reply.
  assign mism1     = z1_sync[SYNC_STAGES-1] ^ a1;
  assign mism2     = z2_sync[SYNC_STAGES-1] ^ a2;
  assign accept    = req_valid & req_ready;
  assign ack       = (state == WAIT) & (sel_q ? ~mism2 : ~mism1);
  assign other_err = sel_q ? mism1 : mism2;

`ifdef DW_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  // The acknowledge wins over an expiry landing in the same cycle.
  assign timeout_hit = (state == WAIT) & ~ack & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept)              wait_cnt <= '0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + CW'(1);
      if (timeout_hit)         timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (ack) state_next = IDLE;
               else if (timeout_hit) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // req_ready stays low through the done cycle because the state is still WAIT there.
  always_comb begin
    req_ready = (state == IDLE);
    done      = ack;
    done_sel  = ack ? sel_q : last_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1           <= 1'b0;
      a2           <= 1'b0;
      fire         <= 1'b0;
      sel_q        <= 1'b0;
      last_sel     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        fire  <= ~fire;
        sel_q <= req_sel;
        if (req_sel) a2 <= ~a2;
        else         a1 <= ~a1;
      end
      if (ack) last_sel <= sel_q;
      if ((state == IDLE && (mism1 | mism2)) ||
          (state == WAIT && (other_err | timeout_hit)))
        protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decision_wait_driver.sv
// Scoreboard bench for decision_wait_driver: a behavioural decision-wait model answers a1/a2,
// a monitor checks every done pulse against the queue of expected channels.
module tb_decision_wait_driver;

  localparam int SS = 2;
  localparam int TO = 16;

  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_sel = 1'b0;
  logic z1 = 1'b0, z2 = 1'b0, auto_en = 1'b0;
  logic req_ready, done, done_sel, protocol_err, timeout, a1, a2, fire;

  int total = 0, bad = 0, cyc = 0, last_accept = 0;
  bit exp_q[$];
  logic exp_a1 = 1'b0, exp_a2 = 1'b0, exp_fire = 1'b0;

  decision_wait_driver #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .done(done), .done_sel(done_sel), .protocol_err(protocol_err), .timeout(timeout),
    .a1(a1), .a2(a2), .fire(fire), .z1(z1), .z2(z2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Decision-wait model: z follows a shortly after the edge; held at 0 while in reset.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      z1 = 1'b0;
      z2 = 1'b0;
    end else if (auto_en) begin
      z1 = a1;
      z2 = a2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done=1 with no outstanding request, done_sel=%0d", done_sel);
      end else begin
        check("done_sel", done_sel, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_a1 = 1'b0; exp_a2 = 1'b0; exp_fire = 1'b0;
    exp_q.delete();
  endtask

  // Called at a negedge; leaves at the negedge after the accepting edge.
  task automatic send(input bit sel);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_sel   = sel;
    @(posedge clk);
    last_accept = cyc;
    #1 req_valid = 1'b0;
    exp_q.push_back(sel);
    exp_fire = ~exp_fire;
    if (sel) exp_a2 = ~exp_a2;
    else     exp_a1 = ~exp_a1;
    @(negedge clk);
    check("a1_after_req", a1, exp_a1);
    check("a2_after_req", a2, exp_a2);
    check("fire_after_req", fire, exp_fire);
    check("ready_in_wait", req_ready, 0);
  endtask

  // lat counts edges after the accepting edge until done is visible.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 100);
    check("done_seen", done, 1);
    check("ready_during_done", req_ready, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", req_ready, 1);
  endtask

  initial begin
    int lat, n, prev_accept;
    bit seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    // 1: reset values, then one channel-1 transaction
    do_reset();
    check("rst_a1", a1, 0);
    check("rst_a2", a2, 0);
    check("rst_fire", fire, 0);
    check("rst_ready", req_ready, 1);
    check("rst_done", done, 0);
    check("rst_done_sel", done_sel, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_timeout", timeout, 0);
    auto_en = 1'b1;
    send(1'b0);
    wait_done(lat);
    check("latency", lat, SS);
    check("done_sel_held", done_sel, 0);

    // 2: back-to-back 0,1,1,0 at the minimum request period
    do_reset();
    prev_accept = 0;
    for (int i = 0; i < 4; i++) begin
      send(seq[i]);
      if (i > 0) check("req_period", last_accept - prev_accept, SS + 2);
      prev_accept = last_accept;
      wait_done(lat);
    end
    check("b2b_fire", fire, 0);
    check("b2b_a1", a1, 0);
    check("b2b_a2", a2, 0);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_perr", protocol_err, 0);

    // 3: stray z2 during a channel-1 WAIT
    auto_en = 1'b0;
    send(1'b0);
    @(posedge clk);
    #2 z2 = ~z2;
    repeat (3) @(negedge clk);
    check("perr_not_yet", protocol_err, 0);
    @(negedge clk);
    check("perr_set", protocol_err, 1);
    z1 = a1;
    wait_done(lat);
    check("perr_sticky", protocol_err, 1);
    check("perr_no_timeout", timeout, 0);

    // 4: reset in the middle of a WAIT, then a clean transaction
    send(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_a1", a1, 0);
    check("midrst_a2", a2, 0);
    check("midrst_fire", fire, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_done", done, 0);
    rst = 1'b0;
    exp_a1 = 1'b0; exp_a2 = 1'b0; exp_fire = 1'b0;
    exp_q.delete();
    check("midrst_perr", protocol_err, 0);
    auto_en = 1'b1;
    send(1'b1);
    wait_done(lat);
    check("midrst_latency", lat, SS);

`ifdef DW_TIMEOUT_EN
    // 5: no reply -> timeout and HALT
    auto_en = 1'b0;
    send(1'b0);
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_flag", timeout, 1);
    check("timeout_perr", protocol_err, 1);
    z1 = a1;
    repeat (20) @(negedge clk);
    check("halt_ready", req_ready, 0);
    check("halt_no_done", exp_q.size(), 1);
    do_reset();
    check("halt_exit_ready", req_ready, 1);
`else
    // 6: no reply for a long time, then a late acknowledge
    auto_en = 1'b0;
    send(1'b0);
    repeat (5000) @(negedge clk);
    check("long_wait_timeout", timeout, 0);
    check("long_wait_ready", req_ready, 0);
    check("long_wait_pending", exp_q.size(), 1);
    z1 = a1;
    wait_done(lat);
    check("late_ack_perr", protocol_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
